dram_word_bridge: RTL and testbench



---
 rtl/dram_bridge_pkg.sv | 19 +
 rtl/dram_bridge_rd_collect.sv | 36 +++
 rtl/dram_word_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_dram_word_bridge.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_bridge_pkg.sv
// rtl/dram_bridge_pkg.sv - shared types and constants for the DRAM word bridge
package dram_bridge_pkg;

  localparam int SDRAM_DW = 16;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LO   = 3'd1,
    RD_HI   = 3'd2,
    RD_WAIT = 3'd3,
    WR_LO   = 3'd4,
    WR_HI   = 3'd5,
    ACK     = 3'd6
  } state_t;

endpackage

// File: rtl/dram_bridge_rd_collect.sv
// rtl/dram_bridge_rd_collect.sv - gathers the two halfword read responses into one word
module dram_bridge_rd_collect
  import dram_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  rdata_valid,
  input  logic [SDRAM_DW-1:0]   rdata,
  output logic                  done,
  output logic [2*SDRAM_DW-1:0] word
);

  logic                have_lo;
  logic [SDRAM_DW-1:0] lo;

  always_ff @(posedge clk) begin
    if (sync_reset || clear) begin
      have_lo <= 1'b0;
      lo      <= '0;
    end else if (enable && rdata_valid) begin
      if (!have_lo) begin
        lo      <= rdata;
        have_lo <= 1'b1;
      end else begin
        have_lo <= 1'b0;
      end
    end
  end

  // Responses return in command order, so the second one is always the high half.
  assign done = enable & rdata_valid & have_lo;
  assign word = {rdata, lo};

endmodule

// File: rtl/dram_word_bridge.sv
// rtl/dram_word_bridge.sv - 32-bit word requests to 16-bit SDRAM command/response bridge
// Optional write posting with a one-entry request queue: DRAM_BRIDGE_WRITE_POST_EN
module dram_word_bridge
  import dram_bridge_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 24,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic [MEM_ADDR_BITS-1:0] dram_mem_addr,
  input  logic                     dram_mem_read_en,
  input  logic                     dram_mem_write_en,
  input  logic [XLEN/8-1:0]        dram_mem_byte_enable,
  input  logic [XLEN-1:0]          dram_mem_write_data,
  output logic                     dram_ack,
  output logic [XLEN-1:0]          dram_mem_read_data,
  output logic [MEM_ADDR_BITS:0]   sdram_addr,
  output logic                     sdram_rd,
  output logic                     sdram_wr,
  output logic [1:0]               sdram_be,
  output logic [SDRAM_DW-1:0]      sdram_wdata,
  input  logic                     sdram_waitrequest,
  input  logic [SDRAM_DW-1:0]      sdram_rdata,
  input  logic                     sdram_rdata_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int BEW = XLEN / 8;

`ifdef DRAM_BRIDGE_WRITE_POST_EN
  localparam bit WRITE_POST = 1'b1;
`else
  localparam bit WRITE_POST = 1'b0;
`endif

  state_t state, state_n;

  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [BEW-1:0]           be_q;
  logic [XLEN-1:0]          data_q;

  logic                     req_valid;
  logic                     req_write;
  logic [MEM_ADDR_BITS-1:0] req_addr;
  logic [BEW-1:0]           req_be;
  logic [XLEN-1:0]          req_data;
  logic                     start;
  logic                     overrun_set;

  logic [MEM_ADDR_BITS-1:0] cap_addr;
  logic [BEW-1:0]           cap_be;
  logic [XLEN-1:0]          cap_data;

  logic                     ack_n;
  logic                     rd_n;
  logic                     wr_n;
  logic [MEM_ADDR_BITS:0]   addr_n;
  logic [1:0]               be_n;
  logic [SDRAM_DW-1:0]      wdata_n;

  logic                     col_done;
  logic [XLEN-1:0]          col_word;
  logic                     accept;
  logic                     q_busy;

  assign accept = !sdram_waitrequest;

`ifdef DRAM_BRIDGE_WRITE_POST_EN
  logic                     q_valid;
  logic                     q_write;
  logic [MEM_ADDR_BITS-1:0] q_addr;
  logic [BEW-1:0]           q_be;
  logic [XLEN-1:0]          q_data;
  logic                     enq;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      q_valid <= 1'b0;
      q_write <= 1'b0;
      q_addr  <= '0;
      q_be    <= '0;
      q_data  <= '0;
    end else if (state == IDLE && q_valid) begin
      q_valid <= 1'b0;
    end else if (enq) begin
      q_valid <= 1'b1;
      q_write <= dram_mem_write_en;
      q_addr  <= dram_mem_addr;
      q_be    <= dram_mem_byte_enable;
      q_data  <= dram_mem_write_data;
    end
  end

  assign q_busy = q_valid;
`else
  assign q_busy = 1'b0;
`endif

  // Request source: the queued entry takes priority over a fresh strobe.
  always_comb begin
    req_valid   = dram_mem_read_en | dram_mem_write_en;
    req_write   = dram_mem_write_en;
    req_addr    = dram_mem_addr;
    req_be      = dram_mem_byte_enable;
    req_data    = dram_mem_write_data;
    overrun_set = dram_mem_read_en & dram_mem_write_en;
`ifdef DRAM_BRIDGE_WRITE_POST_EN
    enq = 1'b0;
    if (q_valid) begin
      req_valid = 1'b1;
      req_write = q_write;
      req_addr  = q_addr;
      req_be    = q_be;
      req_data  = q_data;
      if (dram_mem_read_en || dram_mem_write_en) overrun_set = 1'b1;
    end else if (state != IDLE && (dram_mem_read_en || dram_mem_write_en)) begin
      enq = 1'b1;
    end
`else
    if (state != IDLE && (dram_mem_read_en || dram_mem_write_en)) overrun_set = 1'b1;
`endif
    start = (state == IDLE) && req_valid;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state  <= IDLE;
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        addr_q <= req_addr;
        be_q   <= req_be;
        data_q <= req_data;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!req_write)              state_n = RD_LO;
          else if (req_be == '0)       state_n = ACK;
          else if (req_be[1:0] != 2'b00) state_n = WR_LO;
          else                         state_n = WR_HI;
        end
      end
      RD_LO:   if (accept) state_n = RD_HI;
      RD_HI:   if (accept) state_n = RD_WAIT;
      RD_WAIT: if (col_done) state_n = ACK;
      WR_LO: begin
        if (accept) begin
          if (be_q[3:2] != 2'b00) state_n = WR_HI;
          else                    state_n = WRITE_POST ? IDLE : ACK;
        end
      end
      WR_HI:   if (accept) state_n = WRITE_POST ? IDLE : ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each command appears the cycle after its decision.
  always_comb begin
    cap_addr = start ? req_addr : addr_q;
    cap_be   = start ? req_be   : be_q;
    cap_data = start ? req_data : data_q;

    ack_n   = (state_n == ACK) ||
              (WRITE_POST && start && req_write && (req_be != '0));
    rd_n    = (state_n == RD_LO) || (state_n == RD_HI);
    wr_n    = (state_n == WR_LO) || (state_n == WR_HI);
    addr_n  = sdram_addr;
    be_n    = 2'b00;
    wdata_n = sdram_wdata;
    unique case (state_n)
      RD_LO: begin
        addr_n = {cap_addr, HALF_LO};
        be_n   = 2'b11;
      end
      RD_HI: begin
        addr_n = {cap_addr, HALF_HI};
        be_n   = 2'b11;
      end
      WR_LO: begin
        addr_n  = {cap_addr, HALF_LO};
        be_n    = cap_be[1:0];
        wdata_n = cap_data[SDRAM_DW-1:0];
      end
      WR_HI: begin
        addr_n  = {cap_addr, HALF_HI};
        be_n    = cap_be[3:2];
        wdata_n = cap_data[2*SDRAM_DW-1:SDRAM_DW];
      end
      default: begin
        be_n = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      dram_ack           <= 1'b0;
      sdram_rd           <= 1'b0;
      sdram_wr           <= 1'b0;
      sdram_addr         <= '0;
      sdram_be           <= 2'b00;
      sdram_wdata        <= '0;
      dram_mem_read_data <= '0;
      overrun            <= 1'b0;
    end else begin
      dram_ack    <= ack_n;
      sdram_rd    <= rd_n;
      sdram_wr    <= wr_n;
      sdram_addr  <= addr_n;
      sdram_be    <= be_n;
      sdram_wdata <= wdata_n;
      if (col_done)    dram_mem_read_data <= col_word;
      if (overrun_set) overrun            <= 1'b1;
    end
  end

  assign busy = (state != IDLE) | q_busy;

  dram_bridge_rd_collect u_rd_collect (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .clear       (start),
    .enable      ((state == RD_HI) || (state == RD_WAIT)),
    .rdata_valid (sdram_rdata_valid),
    .rdata       (sdram_rdata),
    .done        (col_done),
    .word        (col_word)
  );

endmodule

// File: tb/tb_dram_word_bridge.sv
// tb/tb_dram_word_bridge.sv - directed self-checking bench for dram_word_bridge
module tb_dram_word_bridge;

`ifdef DRAM_BRIDGE_WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic [23:0] dram_mem_addr = '0;
  logic        dram_mem_read_en = 1'b0;
  logic        dram_mem_write_en = 1'b0;
  logic [3:0]  dram_mem_byte_enable = '0;
  logic [31:0] dram_mem_write_data = '0;
  logic        dram_ack;
  logic [31:0] dram_mem_read_data;
  logic [24:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_wr;
  logic [1:0]  sdram_be;
  logic [15:0] sdram_wdata;
  logic        sdram_waitrequest = 1'b0;
  logic [15:0] sdram_rdata = '0;
  logic        sdram_rdata_valid = 1'b0;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  dram_word_bridge dut (
    .clk                  (clk),
    .sync_reset           (sync_reset),
    .dram_mem_addr        (dram_mem_addr),
    .dram_mem_read_en     (dram_mem_read_en),
    .dram_mem_write_en    (dram_mem_write_en),
    .dram_mem_byte_enable (dram_mem_byte_enable),
    .dram_mem_write_data  (dram_mem_write_data),
    .dram_ack             (dram_ack),
    .dram_mem_read_data   (dram_mem_read_data),
    .sdram_addr           (sdram_addr),
    .sdram_rd             (sdram_rd),
    .sdram_wr             (sdram_wr),
    .sdram_be             (sdram_be),
    .sdram_wdata          (sdram_wdata),
    .sdram_waitrequest    (sdram_waitrequest),
    .sdram_rdata          (sdram_rdata),
    .sdram_rdata_valid    (sdram_rdata_valid),
    .busy                 (busy),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: in-order responses, lat cycles after the accepting cycle.
  int          lat = 2;
  logic [15:0] mem_lo = '0;
  logic [15:0] mem_hi = '0;
  int          rq_sched[$];
  logic [15:0] rq_data[$];

  always @(negedge clk) begin
    if (rq_sched.size() > 0 && rq_sched[0] == cyc) begin
      sdram_rdata_valid = 1'b1;
      sdram_rdata       = rq_data[0];
      rq_sched.delete(0);
      rq_data.delete(0);
    end else begin
      sdram_rdata_valid = 1'b0;
      sdram_rdata       = 16'h0000;
    end
    if (sdram_rd && !sdram_waitrequest) begin
      rq_sched.push_back(cyc + lat);
      rq_data.push_back(sdram_addr[0] ? mem_hi : mem_lo);
    end
  end

  // Command and ack log
  int          cmd_n = 0;
  int          cmd_cyc[256];
  logic [24:0] cmd_addr[256];
  logic [1:0]  cmd_be[256];
  logic [15:0] cmd_wd[256];
  logic        cmd_wr[256];
  logic        cmd_acc[256];
  int          ack_n = 0;
  int          ack_cyc[64];
  logic [31:0] ack_dat[64];

  always @(negedge clk) begin
    if ((sdram_rd || sdram_wr) && cmd_n < 256) begin
      cmd_cyc[cmd_n]  = cyc;
      cmd_addr[cmd_n] = sdram_addr;
      cmd_be[cmd_n]   = sdram_be;
      cmd_wd[cmd_n]   = sdram_wdata;
      cmd_wr[cmd_n]   = sdram_wr;
      cmd_acc[cmd_n]  = !sdram_waitrequest;
      cmd_n = cmd_n + 1;
    end
    if (dram_ack && ack_n < 64) begin
      ack_cyc[ack_n] = cyc;
      ack_dat[ack_n] = dram_mem_read_data;
      ack_n = ack_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [23:0] a,
                       input logic [3:0] be, input logic [31:0] d, output int t0);
    dram_mem_read_en     = rd;
    dram_mem_write_en    = wr;
    dram_mem_addr        = a;
    dram_mem_byte_enable = be;
    dram_mem_write_data  = d;
    t0 = cyc;
    tick();
    dram_mem_read_en  = 1'b0;
    dram_mem_write_en = 1'b0;
  endtask

  task automatic wait_ack(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ack_n > base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({dram_ack, sdram_rd, sdram_wr, busy, overrun} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {dram_ack, sdram_rd, sdram_wr, busy, overrun});
    end
    checks++;
    if (sdram_be !== 2'b00) begin errors++; $display("FAIL reset_be got %b want 00", sdram_be); end
    checks++;
    if (sdram_addr !== 25'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sdram_addr); end
    checks++;
    if (sdram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", sdram_wdata); end
    checks++;
    if (dram_mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", dram_mem_read_data); end
    sync_reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({dram_ack, busy} !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b want 00", {dram_ack, busy}); end
    tick();
  endtask

  task automatic test_read();
    int t0, b, cb;
    bit ok;
    lat = 2; mem_lo = 16'hBEEF; mem_hi = 16'hDEAD;
    b = ack_n; cb = cmd_n;
    issue(1'b1, 1'b0, 24'h000010, 4'h0, 32'h0, t0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got %b want 1", busy); end
    wait_ack(b, ok);
    repeat (4) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL read_ack_timeout got none want ack"); end
    checks++;
    if (ack_cyc[b] - t0 != 5) begin errors++; $display("FAIL read_ack_cycle got %0d want 5", ack_cyc[b] - t0); end
    checks++;
    if (ack_dat[b] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h want deadbeef", ack_dat[b]); end
    checks++;
    if (ack_n - b != 1) begin errors++; $display("FAIL read_ack_count got %0d want 1", ack_n - b); end
    checks++;
    if (cmd_n - cb != 2) begin errors++; $display("FAIL read_cmd_count got %0d want 2", cmd_n - cb); end
    checks++;
    if (cmd_addr[cb] !== 25'h20 || cmd_wr[cb] !== 1'b0 || cmd_cyc[cb] - t0 != 1) begin
      errors++; $display("FAIL read_cmd_lo got addr %h wr %b cyc %0d want 20 0 1", cmd_addr[cb], cmd_wr[cb], cmd_cyc[cb] - t0);
    end
    checks++;
    if (cmd_addr[cb+1] !== 25'h21 || cmd_wr[cb+1] !== 1'b0 || cmd_cyc[cb+1] - t0 != 2) begin
      errors++; $display("FAIL read_cmd_hi got addr %h wr %b cyc %0d want 21 0 2", cmd_addr[cb+1], cmd_wr[cb+1], cmd_cyc[cb+1] - t0);
    end
    checks++;
    if (dram_mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data_held got %h want deadbeef", dram_mem_read_data); end
  endtask

  task automatic test_write_hi();
    int t0, b, cb;
    bit ok;
    b = ack_n; cb = cmd_n;
    issue(1'b0, 1'b1, 24'h000ABC, 4'b1100, 32'h12345678, t0);
    wait_ack(b, ok);
    repeat (4) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_hi_ack_timeout got none want ack"); end
    checks++;
    if (ack_cyc[b] - t0 != (POST ? 1 : 2)) begin errors++; $display("FAIL wr_hi_ack_cycle got %0d want %0d", ack_cyc[b] - t0, POST ? 1 : 2); end
    checks++;
    if (cmd_n - cb != 1) begin errors++; $display("FAIL wr_hi_cmd_count got %0d want 1", cmd_n - cb); end
    checks++;
    if (cmd_wr[cb] !== 1'b1 || cmd_addr[cb] !== 25'h1579 || cmd_cyc[cb] - t0 != 1) begin
      errors++; $display("FAIL wr_hi_cmd got wr %b addr %h cyc %0d want 1 1579 1", cmd_wr[cb], cmd_addr[cb], cmd_cyc[cb] - t0);
    end
    checks++;
    if (cmd_be[cb] !== 2'b11 || cmd_wd[cb] !== 16'h1234) begin
      errors++; $display("FAIL wr_hi_payload got be %b wd %h want 11 1234", cmd_be[cb], cmd_wd[cb]);
    end
    checks++;
    if (dram_mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_keeps_rdata got %h want deadbeef", dram_mem_read_data); end
  endtask

  task automatic test_write_full();
    int t0, b, cb;
    bit ok;
    b = ack_n; cb = cmd_n;
    issue(1'b0, 1'b1, 24'h000001, 4'b1111, 32'hCAFEF00D, t0);
    wait_ack(b, ok);
    repeat (4) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_full_ack_timeout got none want ack"); end
    checks++;
    if (ack_cyc[b] - t0 != (POST ? 1 : 3)) begin errors++; $display("FAIL wr_full_ack_cycle got %0d want %0d", ack_cyc[b] - t0, POST ? 1 : 3); end
    checks++;
    if (cmd_n - cb != 2) begin errors++; $display("FAIL wr_full_cmd_count got %0d want 2", cmd_n - cb); end
    checks++;
    if (cmd_addr[cb] !== 25'h2 || cmd_be[cb] !== 2'b11 || cmd_wd[cb] !== 16'hF00D || cmd_cyc[cb] - t0 != 1) begin
      errors++; $display("FAIL wr_full_lo got addr %h be %b wd %h cyc %0d want 2 11 f00d 1", cmd_addr[cb], cmd_be[cb], cmd_wd[cb], cmd_cyc[cb] - t0);
    end
    checks++;
    if (cmd_addr[cb+1] !== 25'h3 || cmd_be[cb+1] !== 2'b11 || cmd_wd[cb+1] !== 16'hCAFE || cmd_cyc[cb+1] - t0 != 2) begin
      errors++; $display("FAIL wr_full_hi got addr %h be %b wd %h cyc %0d want 3 11 cafe 2", cmd_addr[cb+1], cmd_be[cb+1], cmd_wd[cb+1], cmd_cyc[cb+1] - t0);
    end
  endtask

  task automatic test_write_zero();
    int t0, b, cb;
    bit ok;
    b = ack_n; cb = cmd_n;
    issue(1'b0, 1'b1, 24'h000055, 4'b0000, 32'hFFFFFFFF, t0);
    wait_ack(b, ok);
    repeat (4) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_zero_ack_timeout got none want ack"); end
    checks++;
    if (ack_cyc[b] - t0 != 1) begin errors++; $display("FAIL wr_zero_ack_cycle got %0d want 1", ack_cyc[b] - t0); end
    checks++;
    if (cmd_n - cb != 0) begin errors++; $display("FAIL wr_zero_cmd_count got %0d want 0", cmd_n - cb); end
  endtask

  task automatic test_read_wait();
    int t0, b, cb;
    bit ok;
    lat = 2; mem_lo = 16'h5555; mem_hi = 16'hAAAA;
    b = ack_n; cb = cmd_n;
    sdram_waitrequest = 1'b1;
    issue(1'b1, 1'b0, 24'h000123, 4'h0, 32'h0, t0);
    repeat (3) tick();
    sdram_waitrequest = 1'b0;
    wait_ack(b, ok);
    repeat (4) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_wait_ack_timeout got none want ack"); end
    checks++;
    if (ack_cyc[b] - t0 != 8) begin errors++; $display("FAIL rd_wait_ack_cycle got %0d want 8", ack_cyc[b] - t0); end
    checks++;
    if (ack_dat[b] !== 32'hAAAA5555) begin errors++; $display("FAIL rd_wait_data got %h want aaaa5555", ack_dat[b]); end
    checks++;
    if (cmd_n - cb != 5) begin errors++; $display("FAIL rd_wait_cmd_count got %0d want 5", cmd_n - cb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_addr[cb+i] !== 25'h246 || cmd_cyc[cb+i] - t0 != 1 + i || cmd_acc[cb+i] !== (i == 3)) begin
        errors++; $display("FAIL rd_wait_hold[%0d] got addr %h cyc %0d acc %b want 246 %0d %b",
                           i, cmd_addr[cb+i], cmd_cyc[cb+i] - t0, cmd_acc[cb+i], 1 + i, (i == 3));
      end
    end
    checks++;
    if (cmd_addr[cb+4] !== 25'h247 || cmd_cyc[cb+4] - t0 != 5) begin
      errors++; $display("FAIL rd_wait_hi got addr %h cyc %0d want 247 5", cmd_addr[cb+4], cmd_cyc[cb+4] - t0);
    end
  endtask

  task automatic test_overrun();
    int t0, t1, b, cb;
    bit ok;
    lat = 2; mem_lo = 16'h0F0F; mem_hi = 16'hF0F0;
    b = ack_n; cb = cmd_n;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got %b want 0", overrun); end
    issue(1'b1, 1'b0, 24'h000040, 4'h0, 32'h0, t0);
    repeat (2) tick();
    issue(1'b1, 1'b0, 24'h000077, 4'h0, 32'h0, t1);
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
    wait_ack(b, ok);
    repeat (6) tick();
    checks++;
    if (!ok || ack_cyc[b] - t0 != 5) begin errors++; $display("FAIL overrun_ack_cycle got %0d want 5", ack_cyc[b] - t0); end
    checks++;
    if (ack_dat[b] !== 32'hF0F00F0F) begin errors++; $display("FAIL overrun_data got %h want f0f00f0f", ack_dat[b]); end
    checks++;
    if (ack_n - b != 1 || cmd_n - cb != 2) begin
      errors++; $display("FAIL overrun_counts got acks %0d cmds %0d want 1 2", ack_n - b, cmd_n - cb);
    end
    checks++;
    if (cmd_addr[cb] !== 25'h80 || cmd_addr[cb+1] !== 25'h81) begin
      errors++; $display("FAIL overrun_addrs got %h %h want 80 81", cmd_addr[cb], cmd_addr[cb+1]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, b;
    lat = 3; mem_lo = 16'h1111; mem_hi = 16'h2222;
    b = ack_n;
    issue(1'b1, 1'b0, 24'h000010, 4'h0, 32'h0, t0);
    repeat (2) tick();
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({dram_ack, sdram_rd, sdram_wr, busy, overrun} !== 5'b00000) begin
      errors++; $display("FAIL mid_reset_flags got %b want 00000", {dram_ack, sdram_rd, sdram_wr, busy, overrun});
    end
    checks++;
    if (sdram_addr !== 25'h0 || sdram_be !== 2'b00 || sdram_wdata !== 16'h0) begin
      errors++; $display("FAIL mid_reset_cmd got addr %h be %b wd %h want 0 0 0", sdram_addr, sdram_be, sdram_wdata);
    end
    checks++;
    if (dram_mem_read_data !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got %h want 0", dram_mem_read_data); end
    repeat (8) tick();
    checks++;
    if (ack_n != b) begin errors++; $display("FAIL mid_reset_no_ack got %0d acks want 0", ack_n - b); end
    checks++;
    if (dram_mem_read_data !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL stale_rdata got data %h busy %b want 0 0", dram_mem_read_data, busy);
    end
    lat = 2;
  endtask

  task automatic test_back_to_back();
    int t0, t1, b;
    bit ok;
    lat = 2; mem_lo = 16'h0001; mem_hi = 16'h0002;
    b = ack_n;
    issue(1'b1, 1'b0, 24'h000030, 4'h0, 32'h0, t0);
    wait_ack(b, ok);
    mem_lo = 16'h0003; mem_hi = 16'h0004;
    issue(1'b1, 1'b0, 24'h000031, 4'h0, 32'h0, t1);
    wait_ack(b + 1, ok);
    repeat (3) tick();
    checks++;
    if (ack_dat[b] !== 32'h00020001 || ack_cyc[b] - t0 != 5) begin
      errors++; $display("FAIL b2b_first got %h at %0d want 00020001 at 5", ack_dat[b], ack_cyc[b] - t0);
    end
    checks++;
    if (!ok || ack_dat[b+1] !== 32'h00040003 || ack_cyc[b+1] - t1 != 5) begin
      errors++; $display("FAIL b2b_second got %h at %0d want 00040003 at 5", ack_dat[b+1], ack_cyc[b+1] - t1);
    end
  endtask

  task automatic test_both_strobes();
    int t0, b, cb;
    bit ok;
    b = ack_n; cb = cmd_n;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL both_overrun_before got %b want 0", overrun); end
    issue(1'b1, 1'b1, 24'h000005, 4'b0011, 32'h00009999, t0);
    wait_ack(b, ok);
    repeat (4) tick();
    checks++;
    if (!ok || ack_cyc[b] - t0 != (POST ? 1 : 2)) begin
      errors++; $display("FAIL both_ack_cycle got %0d want %0d", ack_cyc[b] - t0, POST ? 1 : 2);
    end
    checks++;
    if (cmd_n - cb != 1 || cmd_wr[cb] !== 1'b1) begin
      errors++; $display("FAIL both_cmd got count %0d wr %b want 1 1", cmd_n - cb, cmd_wr[cb]);
    end
    checks++;
    if (cmd_addr[cb] !== 25'hA || cmd_be[cb] !== 2'b11 || cmd_wd[cb] !== 16'h9999) begin
      errors++; $display("FAIL both_payload got addr %h be %b wd %h want a 11 9999", cmd_addr[cb], cmd_be[cb], cmd_wd[cb]);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL both_overrun got %b want 1", overrun); end
  endtask

`ifdef DRAM_BRIDGE_WRITE_POST_EN
  task automatic test_posting();
    int t0, t1, b, cb;
    bit ok;
    lat = 2; mem_lo = 16'h3333; mem_hi = 16'h4444;
    b = ack_n; cb = cmd_n;
    issue(1'b0, 1'b1, 24'h000008, 4'b1111, 32'h11112222, t0);
    issue(1'b1, 1'b0, 24'h000009, 4'h0, 32'h0, t1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL post_busy got %b want 1", busy); end
    wait_ack(b + 1, ok);
    repeat (4) tick();
    checks++;
    if (ack_cyc[b] - t0 != 1) begin errors++; $display("FAIL post_wr_ack got %0d want 1", ack_cyc[b] - t0); end
    checks++;
    if (!ok || ack_cyc[b+1] - t0 != 8 || ack_dat[b+1] !== 32'h44443333) begin
      errors++; $display("FAIL post_rd_ack got %h at %0d want 44443333 at 8", ack_dat[b+1], ack_cyc[b+1] - t0);
    end
    checks++;
    if (cmd_n - cb != 4) begin errors++; $display("FAIL post_cmd_count got %0d want 4", cmd_n - cb); end
    checks++;
    if (cmd_wr[cb+1] !== 1'b1 || cmd_addr[cb+1] !== 25'h11 || cmd_cyc[cb+1] - t0 != 2) begin
      errors++; $display("FAIL post_wr_hi got wr %b addr %h cyc %0d want 1 11 2", cmd_wr[cb+1], cmd_addr[cb+1], cmd_cyc[cb+1] - t0);
    end
    checks++;
    if (cmd_wr[cb+2] !== 1'b0 || cmd_addr[cb+2] !== 25'h12 || cmd_cyc[cb+2] - t0 != 4) begin
      errors++; $display("FAIL post_rd_lo got wr %b addr %h cyc %0d want 0 12 4", cmd_wr[cb+2], cmd_addr[cb+2], cmd_cyc[cb+2] - t0);
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL post_overrun got %b want 0", overrun); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_hi();
    test_write_full();
    test_write_zero();
    test_read_wait();
`ifndef DRAM_BRIDGE_WRITE_POST_EN
    test_overrun();
`endif
    test_reset_mid();
    test_back_to_back();
`ifdef DRAM_BRIDGE_WRITE_POST_EN
    test_posting();
`endif
    test_both_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
